// File: rtl/udp_decoder_if.sv
// rtl/udp_decoder_if.sv - IP-side inputs and decoded UDP outputs of udp_decoder
interface udp_decoder_if;
  logic [31:0] src_ip;
  logic [31:0] dest_ip;
  logic [15:0] len_ip;
  logic [31:0] data;
  logic        start;
  logic [15:0] src_port;
  logic [15:0] dest_port;
  logic [15:0] len_udp;
  logic [31:0] data_udp;
  logic        wr_en;
  logic        ok;
  logic        fin;

  modport master (
    output src_ip, dest_ip, len_ip, data, start,
    input  src_port, dest_port, len_udp, data_udp, wr_en, ok, fin
  );

  modport slave (
    input  src_ip, dest_ip, len_ip, data, start,
    output src_port, dest_port, len_udp, data_udp, wr_en, ok, fin
  );
endinterface

// File: rtl/udp_decoder.sv
// rtl/udp_decoder.sv - UDP header/payload decoder; checksum check under UDP_DECODER_CHECKSUM_EN
module udp_decoder (
  input  logic         clk,
  input  logic         reset,
  udp_decoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HDR2, PAYLOAD, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dest_port_q, dest_port_d;
  logic [15:0] len_udp_q, len_udp_d;
  logic [31:0] data_udp_q, data_udp_d;
  logic        wr_en_q, wr_en_d;
  logic        ok_q, ok_d;
  logic        fin_q, fin_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [15:0] complete_checksum;
  logic [31:0] mask;
  logic [31:0] masked;
  logic [15:0] hdr_len;
  logic        len_bad;

  function automatic logic [31:0] ext(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

`ifdef UDP_DECODER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [15:0] cks_q, cks_d;
  logic [15:0] cc_q, cc_d;
  logic [16:0] fold_t;
  logic [15:0] fold_v;
  logic        cks_pass;

  always_comb begin
    fold_t   = {1'b0, sum_q[31:16]} + {1'b0, sum_q[15:0]};
    fold_v   = fold_t[15:0] + {15'h0000, fold_t[16]};
    cks_pass = (fold_v == 16'hFFFF) || (cks_q == 16'h0000);
  end

  assign complete_checksum = cc_q;
`else
  assign complete_checksum = 16'h0000;
`endif

  // Keep only the bytes still inside the datagram on the final payload word.
  always_comb begin
    case (bytes_left_q)
      16'd1:   mask = 32'hFF00_0000;
      16'd2:   mask = 32'hFFFF_0000;
      16'd3:   mask = 32'hFFFF_FF00;
      default: mask = 32'hFFFF_FFFF;
    endcase
    masked  = bus.data & mask;
    hdr_len = bus.data[31:16];
    len_bad = (hdr_len < 16'd8) || (hdr_len != bus.len_ip);
  end

  always_comb begin
    state_d      = state_q;
    src_port_d   = src_port_q;
    dest_port_d  = dest_port_q;
    len_udp_d    = len_udp_q;
    data_udp_d   = data_udp_q;
    wr_en_d      = 1'b0;
    ok_d         = ok_q;
    fin_d        = fin_q;
    bytes_left_d = bytes_left_q;
`ifdef UDP_DECODER_CHECKSUM_EN
    sum_d        = sum_q;
    cks_d        = cks_q;
    cc_d         = cc_q;
`endif
    // A start in any state abandons whatever was in flight.
    if (bus.start) begin
      src_port_d  = bus.data[31:16];
      dest_port_d = bus.data[15:0];
      fin_d       = 1'b0;
      ok_d        = 1'b0;
      state_d     = HDR2;
`ifdef UDP_DECODER_CHECKSUM_EN
      sum_d = ext(bus.src_ip[31:16]) + ext(bus.src_ip[15:0])
            + ext(bus.dest_ip[31:16]) + ext(bus.dest_ip[15:0])
            + ext(16'h0011) + ext(bus.data[31:16]) + ext(bus.data[15:0]);
`endif
    end else begin
      case (state_q)
        HDR2: begin
          len_udp_d = hdr_len;
`ifdef UDP_DECODER_CHECKSUM_EN
          cks_d = bus.data[15:0];
          sum_d = sum_q + ext(bus.data[31:16]) + ext(bus.data[15:0]) + ext(bus.len_ip);
`endif
          if (len_bad) begin
            bytes_left_d = 16'd0;
            fin_d        = 1'b1;
            ok_d         = 1'b0;
            state_d      = DONE;
          end else if (hdr_len == 16'd8) begin
            bytes_left_d = 16'd0;
            state_d      = CHECK;
          end else begin
            bytes_left_d = hdr_len - 16'd8;
            state_d      = PAYLOAD;
          end
        end
        PAYLOAD: begin
          data_udp_d = masked;
          wr_en_d    = 1'b1;
`ifdef UDP_DECODER_CHECKSUM_EN
          sum_d = sum_q + ext(masked[31:16]) + ext(masked[15:0]);
`endif
          if (bytes_left_q <= 16'd4) begin
            bytes_left_d = 16'd0;
            state_d      = CHECK;
          end else begin
            bytes_left_d = bytes_left_q - 16'd4;
          end
        end
        CHECK: begin
          fin_d   = 1'b1;
          state_d = DONE;
`ifdef UDP_DECODER_CHECKSUM_EN
          cc_d = fold_v;
          ok_d = cks_pass;
`else
          ok_d = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      src_port_q   <= 16'h0000;
      dest_port_q  <= 16'h0000;
      len_udp_q    <= 16'h0000;
      data_udp_q   <= 32'h0000_0000;
      wr_en_q      <= 1'b0;
      ok_q         <= 1'b0;
      fin_q        <= 1'b0;
      bytes_left_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      src_port_q   <= src_port_d;
      dest_port_q  <= dest_port_d;
      len_udp_q    <= len_udp_d;
      data_udp_q   <= data_udp_d;
      wr_en_q      <= wr_en_d;
      ok_q         <= ok_d;
      fin_q        <= fin_d;
      bytes_left_q <= bytes_left_d;
    end
  end

`ifdef UDP_DECODER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 32'h0000_0000;
      cks_q <= 16'h0000;
      cc_q  <= 16'h0000;
    end else begin
      sum_q <= sum_d;
      cks_q <= cks_d;
      cc_q  <= cc_d;
    end
  end
`endif

  assign bus.src_port  = src_port_q;
  assign bus.dest_port = dest_port_q;
  assign bus.len_udp   = len_udp_q;
  assign bus.data_udp  = data_udp_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.ok        = ok_q;
  assign bus.fin       = fin_q;

endmodule

// File: tb/tb_udp_decoder.sv
// tb/tb_udp_decoder.sv - directed self-checking bench for udp_decoder
module tb_udp_decoder;

`ifdef UDP_DECODER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  udp_decoder_if bus ();

  udp_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // "Hello World" datagram from 152.1.51.27 to 152.14.94.75; 0x2560 is its correct checksum.
  task automatic run_hello(input logic [15:0] cks, input logic exp_ok, input logic [15:0] exp_cc);
    bus.src_ip  = 32'h9801331B;
    bus.dest_ip = 32'h980E5E4B;
    bus.len_ip  = 16'd19;
    bus.data    = 32'hA08F2694;
    bus.start   = 1'b1;
    cyc();
    chk("src_port", {16'h0, bus.src_port}, 32'h0000A08F);
    chk("dest_port", {16'h0, bus.dest_port}, 32'h00002694);
    chk("fin_cleared", {31'h0, bus.fin}, 32'h0);
    bus.start = 1'b0;
    bus.data  = {16'h0013, cks};
    cyc();
    chk("len_udp", {16'h0, bus.len_udp}, 32'h00000013);
    chk("no_wr_hdr", {31'h0, bus.wr_en}, 32'h0);
    bus.data = 32'h48656C6C;
    cyc();
    chk("wr1", {31'h0, bus.wr_en}, 32'h1);
    chk("pay1", bus.data_udp, 32'h48656C6C);
    bus.data = 32'h6F20576F;
    cyc();
    chk("wr2", {31'h0, bus.wr_en}, 32'h1);
    chk("pay2", bus.data_udp, 32'h6F20576F);
    bus.data = 32'h726C64FF;
    cyc();
    chk("wr3", {31'h0, bus.wr_en}, 32'h1);
    chk("pay3_masked", bus.data_udp, 32'h726C6400);
    chk("fin_early", {31'h0, bus.fin}, 32'h0);
    bus.data = 32'h00000000;
    cyc();
    chk("wr_end", {31'h0, bus.wr_en}, 32'h0);
    chk("fin", {31'h0, bus.fin}, 32'h1);
    chk("ok", {31'h0, bus.ok}, {31'h0, exp_ok});
    chk("cc", {16'h0, dut.complete_checksum}, {16'h0, exp_cc});
    cyc();
    chk("fin_hold", {31'h0, bus.fin}, 32'h1);
    chk("ok_hold", {31'h0, bus.ok}, {31'h0, exp_ok});
  endtask

  initial begin
    bus.src_ip  = 32'h0;
    bus.dest_ip = 32'h0;
    bus.len_ip  = 16'h0;
    bus.data    = 32'h0;
    bus.start   = 1'b0;
    reset       = 1'b0;
    cyc();
    chk("rst_fin", {31'h0, bus.fin}, 32'h0);
    chk("rst_ok", {31'h0, bus.ok}, 32'h0);
    chk("rst_ports", {bus.src_port, bus.dest_port}, 32'h0);
    reset = 1'b1;
    cyc();

    // Correct checksum, wrong checksum, disabled checksum.
    run_hello(16'h2560, 1'b1, CK_EN ? 16'hFFFF : 16'h0000);
    run_hello(16'h0D60, CK_EN ? 1'b0 : 1'b1, CK_EN ? 16'hE7FF : 16'h0000);
    run_hello(16'h0000, 1'b1, CK_EN ? 16'hDA9F : 16'h0000);

    // Reset asserted in the middle of the payload.
    bus.data  = 32'hA08F2694;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.data  = 32'h00132560;
    cyc();
    bus.data = 32'h48656C6C;
    cyc();
    chk("pre_rst_wr", {31'h0, bus.wr_en}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr", {31'h0, bus.wr_en}, 32'h0);
    chk("mid_rst_data", bus.data_udp, 32'h0);
    chk("mid_rst_ports", {bus.src_port, bus.dest_port}, 32'h0);
    chk("mid_rst_len", {16'h0, bus.len_udp}, 32'h0);
    chk("mid_rst_state", 32'(dut.state_q), 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
    run_hello(16'h2560, 1'b1, CK_EN ? 16'hFFFF : 16'h0000);

    // Length field disagrees with the IP layer.
    bus.len_ip = 16'd19;
    bus.data   = 32'hA08F2694;
    bus.start  = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.data  = 32'h00140D60;
    cyc();
    chk("badlen_fin", {31'h0, bus.fin}, 32'h1);
    chk("badlen_ok", {31'h0, bus.ok}, 32'h0);
    chk("badlen_wr", {31'h0, bus.wr_en}, 32'h0);
    bus.data = 32'h48656C6C;
    cyc();
    chk("badlen_wr_after", {31'h0, bus.wr_en}, 32'h0);

    // Start mid-payload aborts without fin, then a header-only datagram.
    bus.data  = 32'hA08F2694;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.data  = 32'h00132560;
    cyc();
    bus.data = 32'h48656C6C;
    cyc();
    bus.len_ip = 16'd8;
    bus.data   = 32'h12345678;
    bus.start  = 1'b1;
    cyc();
    chk("abort_fin", {31'h0, bus.fin}, 32'h0);
    chk("abort_port", {bus.src_port, bus.dest_port}, 32'h12345678);
    bus.data  = 32'hA08F2694;
    cyc();
    bus.start = 1'b0;
    bus.data  = 32'h00087744;
    cyc();
    chk("hdr_only_len", {16'h0, bus.len_udp}, 32'h8);
    chk("hdr_only_fin_n1", {31'h0, bus.fin}, 32'h0);
    bus.data = 32'hDEADBEEF;
    cyc();
    chk("hdr_only_wr", {31'h0, bus.wr_en}, 32'h0);
    chk("hdr_only_fin", {31'h0, bus.fin}, 32'h1);
    chk("hdr_only_ok", {31'h0, bus.ok}, 32'h1);
    chk("hdr_only_cc", {16'h0, dut.complete_checksum}, CK_EN ? 32'h0000FFFF : 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
